calc_centroid_div: RTL and testbench

Sequential divider stage directly downstream of the first-moment (m10) accumulator and the pixel-count (m00) accumulator. Captures the per-frame m10 sum and m00 count from their one-cycle done pulses, then computes the fixed-point horizontal centroid xc = m10 / m00 with a bit-serial restoring divider. Emits the result with a one-cycle valid pulse for the tracking logic. Cleared alongside the accumulators by `cnt_en`.

---
 rtl/calc_centroid_div.sv | 191 +++++++++++++++++++
 tb/tb_calc_centroid_div.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_centroid_div.sv
// rtl/calc_centroid_div.sv - captures m10/m00 and computes xc = m10/m00 with a bit-serial restoring divider
// Optional rounding of the quotient is enabled by defining CALC_CENTROID_ROUND_EN.
module calc_centroid_div #(
  parameter int FRAC_BITS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cnt_en,
  input  logic [31:0]           m10_data,
  input  logic                  m10_done,
  input  logic [31:0]           m00_data,
  input  logic                  m00_done,
  output logic [11+FRAC_BITS-1:0] xc,
  output logic                  xc_valid,
  output logic                  div_err,
  output logic                  busy,
  output logic                  overrun
);

  localparam int QW = 11 + FRAC_BITS;
  localparam int DW = 32 + FRAC_BITS;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_DIV,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     m10_q, m10_d;
  logic [31:0]     m00_q, m00_d;
  logic            have_m10_q, have_m10_d;
  logic            have_m00_q, have_m00_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [31:0]     rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dzero_q, dzero_d;
  logic [QW-1:0]   xc_q, xc_d;
  logic            xc_valid_q, xc_valid_d;
  logic            div_err_q, div_err_d;
  logic            overrun_q, overrun_d;

  logic            busy_w;
  logic [32:0]     rem_sh;
  logic            q_bit;
  logic [DW:0]     q_full;

  assign busy_w = (state_q == S_LOAD) || (state_q == S_DIV) || (state_q == S_FIN);

  always_comb begin
    state_d    = state_q;
    m10_d      = m10_q;
    m00_d      = m00_q;
    have_m10_d = have_m10_q;
    have_m00_d = have_m00_q;
    dvd_d      = dvd_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    dzero_d    = dzero_q;
    xc_d       = xc_q;
    xc_valid_d = 1'b0;
    div_err_d  = div_err_q;
    overrun_d  = overrun_q;
    rem_sh     = {rem_q, dvd_q[DW-1]};
    q_bit      = (rem_sh >= {1'b0, m00_q});
    q_full     = {1'b0, quo_q};

    if (cnt_en) begin
      state_d    = S_IDLE;
      have_m10_d = 1'b0;
      have_m00_d = 1'b0;
      xc_d       = '0;
      div_err_d  = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      // Strobes arriving mid-operation are dropped; the result in flight is untouched.
      if (busy_w && (m10_done || m00_done)) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        S_IDLE, S_WAIT: begin
          if (m10_done) begin
            m10_d      = m10_data;
            have_m10_d = 1'b1;
          end
          if (m00_done) begin
            m00_d      = m00_data;
            have_m00_d = 1'b1;
          end
          if (have_m10_d && have_m00_d) begin
            state_d = S_LOAD;
          end else if (have_m10_d || have_m00_d) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_LOAD: begin
          dvd_d      = {m10_q, {FRAC_BITS{1'b0}}};
          quo_d      = '0;
          rem_d      = '0;
          cnt_d      = '0;
          have_m10_d = 1'b0;
          have_m00_d = 1'b0;
          dzero_d    = (m00_q == 32'd0);
          state_d    = (m00_q == 32'd0) ? S_FIN : S_DIV;
        end

        S_DIV: begin
          // The post-subtract remainder is always below the divisor, so 32 bits hold it.
          rem_d = q_bit ? (rem_sh[31:0] - m00_q) : rem_sh[31:0];
          quo_d = {quo_q[DW-2:0], q_bit};
          dvd_d = {dvd_q[DW-2:0], 1'b0};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DW - 1)) begin
            state_d = S_FIN;
          end
        end

        S_FIN: begin
`ifdef CALC_CENTROID_ROUND_EN
          if ({1'b0, rem_q, 1'b0} >= {2'b00, m00_q}) begin
            q_full = q_full + 1'b1;
          end
`endif
          if (dzero_q) begin
            xc_d      = '0;
            div_err_d = 1'b1;
          end else begin
            xc_d      = (|q_full[DW:QW]) ? {QW{1'b1}} : q_full[QW-1:0];
            div_err_d = 1'b0;
          end
          xc_valid_d = 1'b1;
          state_d    = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      m10_q      <= '0;
      m00_q      <= '0;
      have_m10_q <= 1'b0;
      have_m00_q <= 1'b0;
      dvd_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      dzero_q    <= 1'b0;
      xc_q       <= '0;
      xc_valid_q <= 1'b0;
      div_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m10_q      <= m10_d;
      m00_q      <= m00_d;
      have_m10_q <= have_m10_d;
      have_m00_q <= have_m00_d;
      dvd_q      <= dvd_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      dzero_q    <= dzero_d;
      xc_q       <= xc_d;
      xc_valid_q <= xc_valid_d;
      div_err_q  <= div_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign xc       = xc_q;
  assign xc_valid = xc_valid_q;
  assign div_err  = div_err_q;
  assign busy     = busy_w;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_calc_centroid_div.sv
// tb/tb_calc_centroid_div.sv - scoreboard bench for calc_centroid_div
module tb_calc_centroid_div;

  localparam int FRAC_BITS = 4;
  localparam int QW = 11 + FRAC_BITS;
  localparam int DW = 32 + FRAC_BITS;

  logic          clk = 1'b0;
  logic          nrst;
  logic          cnt_en;
  logic [31:0]   m10_data;
  logic          m10_done;
  logic [31:0]   m00_data;
  logic          m00_done;
  logic [QW-1:0] xc;
  logic          xc_valid;
  logic          div_err;
  logic          busy;
  logic          overrun;

  typedef struct {
    int unsigned xc;
    int unsigned err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cap;

  calc_centroid_div #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .cnt_en   (cnt_en),
    .m10_data (m10_data),
    .m10_done (m10_done),
    .m00_data (m00_data),
    .m00_done (m00_done),
    .xc       (xc),
    .xc_valid (xc_valid),
    .div_err  (div_err),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input int unsigned x, input int unsigned e, input int c);
    exp_t t;
    t.xc  = x;
    t.err = e;
    t.cyc = c;
    sb.push_back(t);
  endtask

  // Drives one strobe cycle; cap_cyc is the edge count right after the capture edge.
  task automatic strobe(input logic [31:0] a, input logic [31:0] b,
                        input logic s10, input logic s00, output int cap_cyc);
    @(posedge clk);
    #1;
    m10_data = a;
    m00_data = b;
    m10_done = s10;
    m00_done = s00;
    @(posedge clk);
    #1;
    m10_done = 1'b0;
    m00_done = 1'b0;
    cap_cyc  = cyc;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout pending=%0d expected=0", nm, sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (nrst && xc_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xc_valid actual=1 expected=0 xc=%0d", xc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xc", xc, e.xc);
        chk("div_err", div_err, e.err);
        chk("latency_cyc", cyc, e.cyc);
        chk("busy_at_valid", busy, 0);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    cnt_en = 1'b0;
    m10_data = '0;
    m00_data = '0;
    m10_done = 1'b0;
    m00_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xc", xc, 0);
    chk("rst_xc_valid", xc_valid, 0);
    chk("rst_div_err", div_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    nrst = 1'b1;

    // Basic: 1000/8 = 125.0
    strobe(32'd1000, 32'd8, 1'b1, 1'b1, cap);
    push(2000, 0, cap + DW + 2);
    chk("busy_after_capture", busy, 1);
    drain("basic");

    // Ordering: m00 first, m10 later
    strobe(32'd0, 32'd3, 1'b0, 1'b1, cap);
    chk("busy_one_operand", busy, 0);
    repeat (4) @(posedge clk);
    strobe(32'd100, 32'd0, 1'b1, 1'b0, cap);
    push(533, 0, cap + DW + 2);
    drain("ordering");

    // Rounding-sensitive case
    strobe(32'd101, 32'd3, 1'b1, 1'b1, cap);
`ifdef CALC_CENTROID_ROUND_EN
    push(539, 0, cap + DW + 2);
`else
    push(538, 0, cap + DW + 2);
`endif
    drain("round");

    // Zero divisor skips DIV
    strobe(32'd500, 32'd0, 1'b1, 1'b1, cap);
    push(0, 1, cap + 2);
    drain("zero_div");
    repeat (3) @(posedge clk);
    #1;
    chk("div_err_held", div_err, 1);
    strobe(32'd16, 32'd1, 1'b1, 1'b1, cap);
    push(256, 0, cap + DW + 2);
    drain("after_zero");

    // Saturation
    strobe(32'h8000_0000, 32'd1, 1'b1, 1'b1, cap);
    push(32767, 0, cap + DW + 2);
    drain("saturate");

    // Overrun: strobe during DIV is dropped
    strobe(32'd1000, 32'd8, 1'b1, 1'b1, cap);
    push(2000, 0, cap + DW + 2);
    repeat (10) @(posedge clk);
    strobe(32'd7, 32'd0, 1'b1, 1'b0, cap);
    chk("overrun_set", overrun, 1);
    drain("overrun_result");
    #1;
    chk("overrun_sticky", overrun, 1);
    chk("idle_after_overrun", busy, 0);

    // Abort mid-DIV with cnt_en
    strobe(32'd16, 32'd1, 1'b1, 1'b1, cap);
    repeat (10) @(posedge clk);
    #1;
    cnt_en = 1'b1;
    @(posedge clk);
    #1;
    cnt_en = 1'b0;
    chk("abort_xc", xc, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_busy", busy, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("abort_no_result_busy", busy, 0);
    strobe(32'd100, 32'd3, 1'b1, 1'b1, cap);
    push(533, 0, cap + DW + 2);
    drain("after_abort");

    // Async reset mid-DIV
    strobe(32'd1000, 32'd8, 1'b1, 1'b1, cap);
    repeat (5) @(posedge clk);
    strobe(32'd7, 32'd7, 1'b1, 1'b1, cap);
    chk("pre_reset_overrun", overrun, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("reset_xc", xc, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_xc_valid", xc_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("post_reset_xc", xc, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
